v810_excseq: RTL and testbench
==============================

Name: v810_excseq

Overview:
- Exception/interrupt sequencer for the V810 core.
- Arbitrates pipeline exceptions (traps, illegal opcode, zero divide, FPU), maskable interrupts and, optionally, NMI against the current PSW.
- Saves PC/PSW through the system-register write port and posts the exception code to ECR via the dedicated ECR strobes.
- Updates PSW with PSW_SET/PSW_RESET masks, then redirects fetch to the handler vector.
- Sits directly upstream of the system-register file and drives its write port while BUSY.

Parameters:
VECTOR_BASE, 32'hFFFF_0000, handler address = VECTOR_BASE | {16'h0, code}

Ports:
CLK  in  1  clock
RES  in  1  synchronous active-high reset
CE  in  1  global clock enable; all state advances only when CE=1
PSW  in  32  current PSW (psw_t) from the system-register file
EXC_REQ  in  1  synchronous exception from the pipeline; held until EXC_ACK
EXC_CODE  in  16  exception code (e.g. FFA0+n trap, FF90 illegal, FF80 zero-div)
EXC_PC  in  32  PC to save for EXC_REQ
INT_REQ  in  1  maskable interrupt request; level-held
INT_LEVEL  in  4  interrupt level 0..15
INT_PC  in  32  restart PC (next instruction) for an interrupt
EXC_ACK  out  1  one-CE pulse: EXC_REQ accepted
INT_ACK  out  1  one-CE pulse: interrupt accepted
BUSY  out  1  sequencer owns SR port; pipeline stalls and must not drive LDSR
SR_WA  out  5  system-register write address (SRSEL_*)
SR_WD  out  32  system-register write data
SR_WE  out  1  system-register write enable
PSW_SET  out  32  PSW bits to set (one cycle)
PSW_RESET  out  32  PSW bits to clear (one cycle)
ECR_CC  out  16  exception code for ECR
ECR_SET_EICC  out  1  load ECR.EICC
ECR_SET_FECC  out  1  load ECR.FECC
REDIR_VALID  out  1  fetch redirect valid
REDIR_PC  out  32  handler address
REDIR_READY  in  1  fetch accepts redirect
FATAL  out  1  fatal exception (NP=1); sticky until RES

Behaviour:
- Reset (RES=1 on a CE edge): state IDLE; all outputs 0, FATAL=0; latched code and PC cleared. RES overrides any state, including mid-sequence and pending REDIR.
- Acceptance in IDLE, evaluated each CE cycle. Priority: EXC_REQ > NMI (if compiled in) > INT_REQ.
- EXC_REQ is always accepted.
- INT_REQ is accepted only when PSW.NP=0, PSW.EP=0, PSW.ID=0 and INT_LEVEL >= PSW.I.
- Interrupt code = 16'hFE00 | (INT_LEVEL<<4).
- Path selection at accept:
  - NP=1: go to FATAL.
  - EP=1, or NMI: duplexed/FE path. Save to FEPC/FEPSW, set ECR.FECC. Vector code 16'hFFD0 for a duplexed exception; the original code goes to FECC.
  - Otherwise: EI path. Save to EIPC/EIPSW, set ECR.EICC.
- Accept cycle (IDLE->SAVE_PC): pulse the matching ACK; latch code, PC, PSW snapshot and path; BUSY=1 from the next cycle.
- SAVE_PC (1 cycle):
  - SR_WE=1, SR_WA=EIPC or FEPC, SR_WD={pc[31:1],1'b0}.
  - ECR_CC=code; ECR_SET_EICC or ECR_SET_FECC=1 (only one).
- SAVE_PSW (1 cycle): SR_WE=1, SR_WA=EIPSW or FEPSW, SR_WD=latched PSW snapshot.
- SET_PSW (1 cycle):
  - EI path: PSW_SET = EP|ID; PSW_RESET = AE.
  - For an interrupt, also write I = min(level+1, 15) via PSW_RESET=I-field, PSW_SET=new I.
  - FE path: PSW_SET = NP|ID; PSW_RESET = AE.
- REDIR: REDIR_VALID=1, REDIR_PC=VECTOR_BASE|code (FFD0 on duplexed). Hold until REDIR_READY=1 on a CE edge, then return to IDLE with BUSY=0.
- Minimum accept-to-IDLE latency: 4 CE cycles + redirect wait. No new acceptance while not IDLE.
- Requests arriving while busy stay pending and are re-evaluated against the new PSW in IDLE.
- FATAL state: FATAL=1, BUSY=1, no writes, no redirect; exit only by RES.
- CE=0: all outputs hold; pulses (ACK, SR_WE, strobes) are gated so each takes effect exactly once.

Optional Feature:
- Macro V810_EXCSEQ_NMI_EN.
- When defined: adds input NMI_REQ (1 bit, edge-captured into a pending flag, cleared at accept) and output NMI_ACK.
  - NMI is accepted regardless of ID/EP/I.
  - NP=1 -> FATAL; otherwise FE path with code 16'hFFD0.
- When undefined: neither port exists and the NMI logic is absent.

Decomposition:
- Shared package holds: psw_t, ecr_t and the SRSEL_* constants (existing); new EXC_CODE_* constants (FE00 interrupt base, FFD0 duplexed/NMI); excseq_state_t enum (IDLE, SAVE_PC, SAVE_PSW, SET_PSW, REDIR, FATAL).
- One sub-module, v810_excseq_arb: combinational acceptance/priority/path selection and code formation.

Test Plan:
- PSW=0, INT_REQ level 5, INT_PC=0x0700_0010 -> INT_ACK; EIPC=0x0700_0010; EIPSW=0; EICC=0xFE50; PSW.EP=ID=1, I=6; REDIR_PC=0xFFFF_FE50.
- PSW.I=8, INT_LEVEL=7 -> never acked. Raise INT_LEVEL to 8 -> accepted, code FE80.
- PSW.EP=1, EXC_REQ code FF90, PC=0x100 -> FEPC=0x100; FECC=FF90; PSW.NP=1; REDIR_PC=0xFFFF_FFD0.
- PSW.NP=1, EXC_REQ -> FATAL=1, no SR_WE, no REDIR; RES=1 -> FATAL=0, IDLE.
- EXC_REQ (FFA3) and INT_REQ in the same cycle -> EXC_ACK only. Interrupt is held off until the handler clears ID/EP.
- REDIR_READY held low 10 cycles; RES asserted at cycle 5 -> REDIR_VALID=0 and BUSY=0 next edge. With CE toggling, each SR_WE is seen once.

Source files
------------

// File: rtl/v810_excseq_pkg.sv
// Shared V810 types and constants for the exception sequencer:
// PSW/ECR layouts, system-register selectors, exception codes and sequencer states.
package v810_excseq_pkg;

  typedef struct packed {
    logic [11:0] rsvd_hi;
    logic [3:0]  i;
    logic        np;
    logic        ep;
    logic        ae;
    logic        id;
    logic [1:0]  rsvd_lo;
    logic [9:0]  flags;
  } psw_t;

  typedef struct packed {
    logic [15:0] fecc;
    logic [15:0] eicc;
  } ecr_t;

  localparam logic [4:0] SRSEL_EIPC  = 5'd0;
  localparam logic [4:0] SRSEL_EIPSW = 5'd1;
  localparam logic [4:0] SRSEL_FEPC  = 5'd2;
  localparam logic [4:0] SRSEL_FEPSW = 5'd3;
  localparam logic [4:0] SRSEL_ECR   = 5'd4;
  localparam logic [4:0] SRSEL_PSW   = 5'd5;

  localparam logic [15:0] EXC_CODE_INT_BASE = 16'hFE00;
  localparam logic [15:0] EXC_CODE_DUP      = 16'hFFD0;

  localparam logic [31:0] PSW_ID_MASK = 32'h0000_1000;
  localparam logic [31:0] PSW_AE_MASK = 32'h0000_2000;
  localparam logic [31:0] PSW_EP_MASK = 32'h0000_4000;
  localparam logic [31:0] PSW_NP_MASK = 32'h0000_8000;
  localparam logic [31:0] PSW_I_MASK  = 32'h000F_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_PC  = 3'd1,
    ST_SAVE_PSW = 3'd2,
    ST_SET_PSW  = 3'd3,
    ST_REDIR    = 3'd4,
    ST_FATAL    = 3'd5
  } excseq_state_t;

endpackage

// File: rtl/v810_excseq_arb.sv
// Combinational acceptance arbiter for the V810 exception sequencer.
// Priority EXC > NMI > INT; picks EI/FE/fatal path and forms ECR and vector codes.
// NMI input present only when V810_EXCSEQ_NMI_EN is defined.
module v810_excseq_arb
  import v810_excseq_pkg::*;
(
  input  logic        psw_np,
  input  logic        psw_ep,
  input  logic        psw_id,
  input  logic [3:0]  psw_i,
  input  logic        exc_req,
  input  logic [15:0] exc_code,
  input  logic        int_req,
  input  logic [3:0]  int_level,
`ifdef V810_EXCSEQ_NMI_EN
  input  logic        nmi_pend,
  output logic        acc_nmi,
`endif
  output logic        acc_exc,
  output logic        acc_int,
  output logic        acc_any,
  output logic        go_fatal,
  output logic        fe_path,
  output logic [15:0] ecr_code,
  output logic [15:0] vec_code
);

  logic        int_ok;
  logic [15:0] int_code;

  assign int_ok   = int_req & ~psw_np & ~psw_ep & ~psw_id & (int_level >= psw_i);
  assign int_code = EXC_CODE_INT_BASE | {8'h00, int_level, 4'h0};

  // Priority selection and code formation for the highest pending source
  always_comb begin
    acc_exc  = 1'b0;
    acc_int  = 1'b0;
    go_fatal = 1'b0;
    fe_path  = 1'b0;
    ecr_code = 16'h0000;
    vec_code = 16'h0000;
`ifdef V810_EXCSEQ_NMI_EN
    acc_nmi  = 1'b0;
`endif
    if (exc_req) begin
      // An exception while already in a handler (EP) is duplexed: vector FFD0, original code to FECC
      acc_exc  = 1'b1;
      go_fatal = psw_np;
      fe_path  = psw_ep;
      ecr_code = exc_code;
      vec_code = psw_ep ? EXC_CODE_DUP : exc_code;
`ifdef V810_EXCSEQ_NMI_EN
    end else if (nmi_pend) begin
      acc_nmi  = 1'b1;
      go_fatal = psw_np;
      fe_path  = 1'b1;
      ecr_code = EXC_CODE_DUP;
      vec_code = EXC_CODE_DUP;
`endif
    end else if (int_ok) begin
      acc_int  = 1'b1;
      ecr_code = int_code;
      vec_code = int_code;
    end
  end

`ifdef V810_EXCSEQ_NMI_EN
  assign acc_any = acc_exc | acc_nmi | acc_int;
`else
  assign acc_any = acc_exc | acc_int;
`endif

endmodule

// File: rtl/v810_excseq.sv
// V810 exception/interrupt sequencer: accepts a request, saves PC/PSW through the
// system-register write port, posts ECR, updates PSW and redirects fetch.
// Optional NMI input/ack enabled by defining V810_EXCSEQ_NMI_EN.
module v810_excseq
  import v810_excseq_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] PSW,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LEVEL,
  input  logic [31:0] INT_PC,
`ifdef V810_EXCSEQ_NMI_EN
  input  logic        NMI_REQ,
  output logic        NMI_ACK,
`endif
  output logic        EXC_ACK,
  output logic        INT_ACK,
  output logic        BUSY,
  output logic [4:0]  SR_WA,
  output logic [31:0] SR_WD,
  output logic        SR_WE,
  output logic [31:0] PSW_SET,
  output logic [31:0] PSW_RESET,
  output logic [15:0] ECR_CC,
  output logic        ECR_SET_EICC,
  output logic        ECR_SET_FECC,
  output logic        REDIR_VALID,
  output logic [31:0] REDIR_PC,
  input  logic        REDIR_READY,
  output logic        FATAL
);

  // Interrupt level raise saturates at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  psw_t          psw_in;
  excseq_state_t state_q, state_nx;

  logic        acc_exc, acc_int, acc_any, go_fatal, fe_path;
  logic [15:0] ecr_code, vec_code;
  logic        pulse_en;

  logic [15:0] code_p0;
  logic [15:0] vec_p0;
  logic [31:0] pc_p0;
  logic [31:0] psw_p0;
  logic        fe_p0;
  logic        int_p0;
  logic [3:0]  lvl_p0;

  assign psw_in   = psw_t'(PSW);
  // Single-shot outputs only take effect on an enabled, non-reset edge
  assign pulse_en = CE & ~RES;

`ifdef V810_EXCSEQ_NMI_EN
  logic acc_nmi;
  logic nmi_prev, nmi_pend;

  // NMI rising-edge capture into a pending flag, cleared when accepted
  always_ff @(posedge CLK) begin
    if (RES) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else if (CE) begin
      nmi_prev <= NMI_REQ;
      if (NMI_REQ && !nmi_prev)
        nmi_pend <= 1'b1;
      else if (state_q == ST_IDLE && acc_nmi)
        nmi_pend <= 1'b0;
    end
  end
`endif

  v810_excseq_arb u_arb (
    .psw_np    (psw_in.np),
    .psw_ep    (psw_in.ep),
    .psw_id    (psw_in.id),
    .psw_i     (psw_in.i),
    .exc_req   (EXC_REQ),
    .exc_code  (EXC_CODE),
    .int_req   (INT_REQ),
    .int_level (INT_LEVEL),
`ifdef V810_EXCSEQ_NMI_EN
    .nmi_pend  (nmi_pend),
    .acc_nmi   (acc_nmi),
`endif
    .acc_exc   (acc_exc),
    .acc_int   (acc_int),
    .acc_any   (acc_any),
    .go_fatal  (go_fatal),
    .fe_path   (fe_path),
    .ecr_code  (ecr_code),
    .vec_code  (vec_code)
  );

  // State register; reset overrides any state including a pending redirect
  always_ff @(posedge CLK) begin
    if (RES)
      state_q <= ST_IDLE;
    else if (CE)
      state_q <= state_nx;
  end

  // Next-state sequencing: accept, two saves, PSW update, redirect handshake
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:     if (acc_any) state_nx = go_fatal ? ST_FATAL : ST_SAVE_PC;
      ST_SAVE_PC:  state_nx = ST_SAVE_PSW;
      ST_SAVE_PSW: state_nx = ST_SET_PSW;
      ST_SET_PSW:  state_nx = ST_REDIR;
      ST_REDIR:    if (REDIR_READY) state_nx = ST_IDLE;
      ST_FATAL:    state_nx = ST_FATAL;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Capture of the accepted request: codes, restart PC, PSW snapshot and path
  always_ff @(posedge CLK) begin
    if (RES) begin
      code_p0 <= 16'h0000;
      vec_p0  <= 16'h0000;
      pc_p0   <= 32'h0000_0000;
      psw_p0  <= 32'h0000_0000;
      fe_p0   <= 1'b0;
      int_p0  <= 1'b0;
      lvl_p0  <= 4'h0;
    end else if (CE && state_q == ST_IDLE && acc_any) begin
      code_p0 <= ecr_code;
      vec_p0  <= vec_code;
      pc_p0   <= acc_exc ? EXC_PC : INT_PC;
      psw_p0  <= PSW;
      fe_p0   <= fe_path;
      int_p0  <= acc_int;
      lvl_p0  <= INT_LEVEL;
    end
  end

  // Output decode per state; pulses gated so each is consumed on exactly one edge
  always_comb begin
    EXC_ACK      = 1'b0;
    INT_ACK      = 1'b0;
    BUSY         = 1'b0;
    SR_WA        = 5'd0;
    SR_WD        = 32'h0000_0000;
    SR_WE        = 1'b0;
    PSW_SET      = 32'h0000_0000;
    PSW_RESET    = 32'h0000_0000;
    ECR_CC       = 16'h0000;
    ECR_SET_EICC = 1'b0;
    ECR_SET_FECC = 1'b0;
    REDIR_VALID  = 1'b0;
    REDIR_PC     = 32'h0000_0000;
    FATAL        = 1'b0;
`ifdef V810_EXCSEQ_NMI_EN
    NMI_ACK      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        EXC_ACK = pulse_en & acc_exc;
        INT_ACK = pulse_en & acc_int;
`ifdef V810_EXCSEQ_NMI_EN
        NMI_ACK = pulse_en & acc_nmi;
`endif
      end
      ST_SAVE_PC: begin
        BUSY         = 1'b1;
        SR_WE        = pulse_en;
        SR_WA        = fe_p0 ? SRSEL_FEPC : SRSEL_EIPC;
        SR_WD        = pc_p0 & 32'hFFFF_FFFE;
        ECR_CC       = code_p0;
        ECR_SET_FECC = pulse_en & fe_p0;
        ECR_SET_EICC = pulse_en & ~fe_p0;
      end
      ST_SAVE_PSW: begin
        BUSY  = 1'b1;
        SR_WE = pulse_en;
        SR_WA = fe_p0 ? SRSEL_FEPSW : SRSEL_EIPSW;
        SR_WD = psw_p0;
      end
      ST_SET_PSW: begin
        BUSY = 1'b1;
        if (pulse_en) begin
          PSW_SET   = fe_p0 ? (PSW_NP_MASK | PSW_ID_MASK) : (PSW_EP_MASK | PSW_ID_MASK);
          PSW_RESET = PSW_AE_MASK;
          if (int_p0) begin
            PSW_SET   = PSW_SET | {12'h000, sat_inc4(lvl_p0), 16'h0000};
            PSW_RESET = PSW_RESET | PSW_I_MASK;
          end
        end
      end
      ST_REDIR: begin
        BUSY        = 1'b1;
        REDIR_VALID = 1'b1;
        REDIR_PC    = VECTOR_BASE | {16'h0000, vec_p0};
      end
      ST_FATAL: begin
        BUSY  = 1'b1;
        FATAL = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_v810_excseq.sv
// Self-checking bench for v810_excseq: table of request scenarios feeding an
// event scoreboard, plus hand-written fatal, hold-off, reset-in-redirect and CE sequences.
module tb_v810_excseq;
  import v810_excseq_pkg::*;

  logic        CLK, RES, CE;
  logic [31:0] PSW;
  logic        EXC_REQ;
  logic [15:0] EXC_CODE;
  logic [31:0] EXC_PC;
  logic        INT_REQ;
  logic [3:0]  INT_LEVEL;
  logic [31:0] INT_PC;
  logic        EXC_ACK, INT_ACK, BUSY, SR_WE;
  logic [4:0]  SR_WA;
  logic [31:0] SR_WD, PSW_SET, PSW_RESET, REDIR_PC;
  logic [15:0] ECR_CC;
  logic        ECR_SET_EICC, ECR_SET_FECC, REDIR_VALID, REDIR_READY, FATAL;
`ifdef V810_EXCSEQ_NMI_EN
  logic        NMI_REQ = 1'b0;
  logic        NMI_ACK;
`endif

  v810_excseq dut (
    .CLK(CLK), .RES(RES), .CE(CE), .PSW(PSW),
    .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC),
    .INT_REQ(INT_REQ), .INT_LEVEL(INT_LEVEL), .INT_PC(INT_PC),
`ifdef V810_EXCSEQ_NMI_EN
    .NMI_REQ(NMI_REQ), .NMI_ACK(NMI_ACK),
`endif
    .EXC_ACK(EXC_ACK), .INT_ACK(INT_ACK), .BUSY(BUSY),
    .SR_WA(SR_WA), .SR_WD(SR_WD), .SR_WE(SR_WE),
    .PSW_SET(PSW_SET), .PSW_RESET(PSW_RESET),
    .ECR_CC(ECR_CC), .ECR_SET_EICC(ECR_SET_EICC), .ECR_SET_FECC(ECR_SET_FECC),
    .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .REDIR_READY(REDIR_READY),
    .FATAL(FATAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard event kinds
  localparam int EV_SRW = 0, EV_ECR = 1, EV_PSWU = 2, EV_REDIR = 3, EV_ACK = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  typedef struct {
    logic [31:0] psw;
    bit          is_int;
    logic [15:0] code;
    logic [31:0] pc;
    logic [3:0]  lvl;
    bit          fe;
    logic [31:0] saved_pc;
    logic [15:0] ecr;
    logic [15:0] vec;
    logic [31:0] set;
    logic [31:0] rst;
    logic [31:0] psw_after;
  } vec_t;

  ev_t         evq[$];
  vec_t        vecs[5];
  int          total = 0;
  int          bad   = 0;
  bit          ack_exc_seen = 0, ack_int_seen = 0, ce_rand = 0;
  logic [31:0] last_set = 0, last_reset = 0;

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    evq.push_back(e);
  endtask

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] b, input string nm);
    ev_t e;
    total++;
    if (evq.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected: got a=%h b=%h, want no event", nm, a, b);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL %s: got kind=%0d a=%h b=%h, want kind=%0d a=%h b=%h",
                 nm, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Observe DUT output events away from the active edge
  task automatic sample();
    if (CE && !RES) begin
      if (EXC_ACK) begin expect_ev(EV_ACK, 32'd0, 32'd0, "exc_ack"); ack_exc_seen = 1; end
      if (INT_ACK) begin expect_ev(EV_ACK, 32'd1, 32'd0, "int_ack"); ack_int_seen = 1; end
      if (SR_WE) expect_ev(EV_SRW, {27'd0, SR_WA}, SR_WD, "sr_write");
      if (ECR_SET_EICC || ECR_SET_FECC)
        expect_ev(EV_ECR, {16'd0, ECR_CC}, {30'd0, ECR_SET_FECC, ECR_SET_EICC}, "ecr");
      if (PSW_SET != 0 || PSW_RESET != 0) begin
        expect_ev(EV_PSWU, PSW_SET, PSW_RESET, "psw_update");
        last_set = PSW_SET; last_reset = PSW_RESET;
      end
      if (REDIR_VALID && REDIR_READY) expect_ev(EV_REDIR, REDIR_PC, 32'd0, "redirect");
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
    if (ack_exc_seen) begin EXC_REQ = 1'b0; ack_exc_seen = 0; end
    if (ack_int_seen) begin INT_REQ = 1'b0; ack_int_seen = 0; end
    if (ce_rand) CE = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    tick();
    while ((evq.size() != 0 || BUSY) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s timeout: got %0d events left, want 0", nm, evq.size());
      evq.delete();
    end
  endtask

  task automatic push_seq(input logic [31:0] psw, input bit is_int, input bit fe,
                          input logic [31:0] spc, input logic [15:0] ecr, input logic [15:0] vec,
                          input logic [31:0] set, input logic [31:0] rst);
    push(EV_ACK, is_int ? 32'd1 : 32'd0, 32'd0);
    push(EV_SRW, {27'd0, fe ? SRSEL_FEPC : SRSEL_EIPC}, spc);
    push(EV_ECR, {16'd0, ecr}, fe ? 32'd2 : 32'd1);
    push(EV_SRW, {27'd0, fe ? SRSEL_FEPSW : SRSEL_EIPSW}, psw);
    push(EV_PSWU, set, rst);
    push(EV_REDIR, 32'hFFFF_0000 | {16'd0, vec}, 32'd0);
  endtask

  initial begin
    //        psw           int code      pc            lvl   fe saved_pc      ecr       vec       set           rst           psw_after
    vecs[0] = '{32'h0000_0000, 1, 16'h0000, 32'h0700_0010, 4'd5,  0, 32'h0700_0010, 16'hFE50, 16'hFE50, 32'h0006_5000, 32'h000F_2000, 32'h0006_5000};
    vecs[1] = '{32'h0008_0000, 1, 16'h0000, 32'h0000_2000, 4'd8,  0, 32'h0000_2000, 16'hFE80, 16'hFE80, 32'h0009_5000, 32'h000F_2000, 32'h0009_5000};
    vecs[2] = '{32'h0000_4000, 0, 16'hFF90, 32'h0000_0100, 4'd0,  1, 32'h0000_0100, 16'hFF90, 16'hFFD0, 32'h0000_9000, 32'h0000_2000, 32'h0000_D000};
    vecs[3] = '{32'h000F_0000, 1, 16'h0000, 32'h0000_4444, 4'd15, 0, 32'h0000_4444, 16'hFEF0, 16'hFEF0, 32'h000F_5000, 32'h000F_2000, 32'h000F_5000};
    vecs[4] = '{32'h0000_1000, 0, 16'hFF80, 32'h0000_8001, 4'd0,  0, 32'h0000_8000, 16'hFF80, 16'hFF80, 32'h0000_5000, 32'h0000_2000, 32'h0000_5000};

    RES = 1; CE = 1; PSW = 0; EXC_REQ = 0; EXC_CODE = 0; EXC_PC = 0;
    INT_REQ = 0; INT_LEVEL = 0; INT_PC = 0; REDIR_READY = 1;
    @(posedge CLK); #1;
    tick(); tick();
    RES = 0;
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_fatal", {31'd0, FATAL}, 32'd0);
    check("reset_redir", {31'd0, REDIR_VALID}, 32'd0);
    check("reset_srwe", {31'd0, SR_WE}, 32'd0);

    // Interrupt below PSW.I is never accepted
    PSW = 32'h0008_0000; INT_LEVEL = 4'd7; INT_PC = 32'h0000_2000; INT_REQ = 1;
    for (int i = 0; i < 20; i++) tick();
    check("masked_int_busy", {31'd0, BUSY}, 32'd0);
    INT_REQ = 0;

    for (int v = 0; v < 5; v++) begin
      PSW = vecs[v].psw;
      push_seq(vecs[v].psw, vecs[v].is_int, vecs[v].fe, vecs[v].saved_pc,
               vecs[v].ecr, vecs[v].vec, vecs[v].set, vecs[v].rst);
      if (vecs[v].is_int) begin
        INT_LEVEL = vecs[v].lvl; INT_PC = vecs[v].pc; INT_REQ = 1;
      end else begin
        EXC_CODE = vecs[v].code; EXC_PC = vecs[v].pc; EXC_REQ = 1;
      end
      wait_done(60, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_psw", v), (vecs[v].psw & ~last_reset) | last_set, vecs[v].psw_after);
      EXC_REQ = 0; INT_REQ = 0;
    end

    // NP=1 exception goes fatal: ack only, no writes, no redirect, until reset
    PSW = 32'h0000_8000; EXC_CODE = 16'hFF90; EXC_PC = 32'h0000_0400; EXC_REQ = 1;
    push(EV_ACK, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("fatal_flag", {31'd0, FATAL}, 32'd1);
    check("fatal_busy", {31'd0, BUSY}, 32'd1);
    check("fatal_noredir", {31'd0, REDIR_VALID}, 32'd0);
    check("fatal_events", evq.size(), 32'd0);
    evq.delete();
    RES = 1; tick(); RES = 0;
    check("fatal_cleared", {30'd0, FATAL, BUSY}, 32'd0);

    // Simultaneous EXC and INT: exception wins, interrupt waits for handler to clear EP/ID
    PSW = 32'h0000_2005; EXC_CODE = 16'hFFA3; EXC_PC = 32'h0000_0201; EXC_REQ = 1;
    INT_LEVEL = 4'd3; INT_PC = 32'h0000_0300; INT_REQ = 1;
    push_seq(32'h0000_2005, 0, 0, 32'h0000_0200, 16'hFFA3, 16'hFFA3, 32'h0000_5000, 32'h0000_2000);
    wait_done(60, "exc_over_int");
    PSW = (PSW & ~last_reset) | last_set;
    check("exc_over_int_psw", PSW, 32'h0000_5005);
    for (int i = 0; i < 15; i++) tick();
    check("int_held_off", {31'd0, BUSY}, 32'd0);
    PSW = 32'h0000_0005;
    push_seq(32'h0000_0005, 1, 0, 32'h0000_0300, 16'hFE30, 16'hFE30, 32'h0004_5000, 32'h000F_2000);
    wait_done(60, "int_after_reti");
    INT_REQ = 0;

    // Reset while the redirect is stalled drops REDIR_VALID and BUSY on the next edge
    REDIR_READY = 0; PSW = 0; EXC_CODE = 16'hFF80; EXC_PC = 32'h0000_1234; EXC_REQ = 1;
    push(EV_ACK, 32'd0, 32'd0);
    push(EV_SRW, {27'd0, SRSEL_EIPC}, 32'h0000_1234);
    push(EV_ECR, 32'h0000_FF80, 32'd1);
    push(EV_SRW, {27'd0, SRSEL_EIPSW}, 32'h0000_0000);
    push(EV_PSWU, 32'h0000_5000, 32'h0000_2000);
    begin
      int n = 0;
      while (!REDIR_VALID && n < 20) begin tick(); n++; end
    end
    check("redir_wait_valid", {31'd0, REDIR_VALID}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("redir_held", {31'd0, REDIR_VALID}, 32'd1);
    check("redir_pc", REDIR_PC, 32'hFFFF_FF80);
    RES = 1; tick(); RES = 0;
    check("redir_reset", {30'd0, REDIR_VALID, BUSY}, 32'd0);
    check("redir_events", evq.size(), 32'd0);
    evq.delete();
    REDIR_READY = 1;

    // Random CE gaps: every event must still appear exactly once
    ce_rand = 1; PSW = 0; INT_LEVEL = 4'd2; INT_PC = 32'h0000_0AA0; INT_REQ = 1;
    push_seq(32'h0000_0000, 1, 0, 32'h0000_0AA0, 16'hFE20, 16'hFE20, 32'h0003_5000, 32'h000F_2000);
    wait_done(400, "ce_toggle");
    ce_rand = 0; CE = 1; INT_REQ = 0;
    for (int i = 0; i < 5; i++) tick();
    check("ce_toggle_idle", {31'd0, BUSY}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
